// File: rtl/branch_predictor.sv
// Direct-mapped bimodal predictor with BTB; prediction is combinational, training is visible the cycle after upd_valid.
// No backpressure: one resolved branch is accepted on every clock.
module branch_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CTR_INIT   = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 2;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
  } btb_t;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  btb_t               btb_q [ENTRIES];

  logic [INDEX_BITS-1:0] pred_idx;
  logic [TAG_BITS-1:0]   pred_tag;
  btb_t                  pred_entry;

  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic [1:0]            ctr_nxt;
  logic                  mispredict;

  // Instruction alignment makes the two low PC bits meaningless here.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pred_pc[1:0], upd_pc[1:0]};

  assign pred_idx    = pred_pc[INDEX_BITS+1:2];
  assign pred_tag    = pred_pc[31:INDEX_BITS+2];
  assign pred_entry  = btb_q[pred_idx];
  assign pred_hit    = valid_q[pred_idx] && (pred_entry.tag == pred_tag);
  assign pred_taken  = pred_hit && ctr_q[pred_idx][1];
  assign pred_target = pred_taken ? pred_entry.target : (pred_pc + 32'd4);

  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign upd_tag = upd_pc[31:INDEX_BITS+2];
  assign upd_hit = valid_q[upd_idx] && (btb_q[upd_idx].tag == upd_tag);

  // A correct direction with a stale target still redirects fetch wrongly.
  assign mispredict = (upd_pred_taken != upd_taken) ||
                      (upd_taken && upd_pred_taken && (upd_pred_target != upd_target));

  always_comb begin
    ctr_nxt = ctr_q[upd_idx];
    if (upd_taken) begin
      if (ctr_nxt != 2'b11) ctr_nxt = ctr_nxt + 2'd1;
    end else begin
      if (ctr_nxt != 2'b00) ctr_nxt = ctr_nxt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_nxt;
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_INIT;
      end
      if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  // Tag/target carry no reset; valid_q guards them. On a hit the tag rewrite is a no-op.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      btb_q[upd_idx] <= '{tag: upd_tag, target: upd_target};
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded random + directed bench for branch_predictor against an entry-level reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic [31:0] stat_branches, stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(6), .CTR_INIT(2'b10)) dut (
    .clk(clk), .rst(rst),
    .pred_pc(pred_pc), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Reference model: 64 entries addressed by (pc/4)%64, tag pc/256, counter as a bounded integer.
  typedef struct {
    bit          v;
    logic [31:0] tag;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;
  ent_t            m [64];
  longint unsigned m_br, m_mp;
  localparam longint unsigned SAT = 64'hFFFF_FFFF;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;
  exp_t q[$];

  int  checks = 0;
  int  passed = 0;
  bit  armed  = 1'b0;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic hit,
                                        output logic taken, output logic [31:0] tgt);
    int i;
    i     = m_idx(pc);
    hit   = m[i].v && (m[i].tag == (pc >> 8));
    taken = hit && (m[i].ctr >= 2);
    tgt   = taken ? m[i].tgt : pc + 32'd4;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m[i].v   = 1'b0;
      m[i].ctr = 1;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                                       input logic pt, input logic [31:0] ptgt);
    int i;
    i = m_idx(pc);
    if (m[i].v && (m[i].tag == (pc >> 8))) begin
      if (t) begin
        m[i].ctr = (m[i].ctr < 3) ? m[i].ctr + 1 : 3;
        m[i].tgt = tgt;
      end else begin
        m[i].ctr = (m[i].ctr > 0) ? m[i].ctr - 1 : 0;
      end
    end else if (t) begin
      m[i].v   = 1'b1;
      m[i].tag = pc >> 8;
      m[i].tgt = tgt;
      m[i].ctr = 2;
    end
    if (m_br < SAT) m_br++;
    if (((pt != t) || (t && pt && (ptgt != tgt))) && (m_mp < SAT)) m_mp++;
  endfunction

  // One clock of stimulus; the expectation reflects model state before this cycle's edge.
  task automatic cycle(input logic r, input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic pt, input logic [31:0] ptgt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; pred_pc = pc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = pt; upd_pred_target = ptgt;
    if (armed) begin
      model_predict(pc, e.hit, e.taken, e.target);
      e.br = m_br[31:0];
      e.mp = m_mp[31:0];
      q.push_back(e);
    end
    if (r) begin
      model_reset();
      armed = 1'b1;
    end else if (uv) begin
      model_update(upc, ut, utgt, pt, ptgt);
    end
  endtask

  task automatic idle(input logic [31:0] pc);
    cycle(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Update whose fetch-time prediction is taken from the model, so only the outcome can mispredict.
  task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    logic h, pt;
    logic [31:0] ptgt;
    model_predict(pc, h, pt, ptgt);
    cycle(1'b0, 32'h0, 1'b1, pc, t, tgt, pt, ptgt);
  endtask

  task automatic expect_pred(input string name, input logic h, input logic t, input logic [31:0] tgt);
    @(negedge clk);
    #1;
    checks++;
    if (pred_hit === h && pred_taken === t && pred_target === tgt) passed++;
    else $display("FAIL %s: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                  name, pred_hit, pred_taken, pred_target, h, t, tgt);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (pred_hit === e.hit && pred_taken === e.taken && pred_target === e.target) passed++;
      else $display("FAIL pred @%0t pc=%h: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                    $time, pred_pc, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.target);
      checks++;
      if (stat_branches === e.br) passed++;
      else $display("FAIL stat_branches @%0t: got %0d want %0d", $time, stat_branches, e.br);
      checks++;
      if (stat_mispredicts === e.mp) passed++;
      else $display("FAIL stat_mispredicts @%0t: got %0d want %0d", $time, stat_mispredicts, e.mp);
    end
  end

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    rst = 1'b1; pred_pc = 32'h0; upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;

    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);
    expect_pred("reset_pred", 1'b0, 1'b0, 32'h104);

    cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    idle(32'h100);
    expect_pred("alloc", 1'b1, 1'b1, 32'h80);

    train(32'h100, 1'b0, 32'h0);
    idle(32'h100);
    expect_pred("dec_to_01", 1'b1, 1'b0, 32'h104);
    repeat (3) train(32'h100, 1'b0, 32'h0);
    idle(32'h100);
    repeat (4) train(32'h100, 1'b1, 32'h80);
    idle(32'h100);
    expect_pred("sat_high", 1'b1, 1'b1, 32'h80);
    repeat (2) train(32'h100, 1'b0, 32'h0);
    idle(32'h100);
    expect_pred("sat_high_dec2", 1'b1, 1'b0, 32'h104);

    train(32'h200, 1'b1, 32'h300);
    idle(32'h200);
    expect_pred("alias_new", 1'b1, 1'b1, 32'h300);
    idle(32'h100);
    expect_pred("alias_old", 1'b0, 1'b0, 32'h104);

    cycle(1'b0, 32'h14, 1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h14);
    expect_pred("nt_no_alloc", 1'b0, 1'b0, 32'h18);

    cycle(1'b0, 32'h0, 1'b1, 32'h24, 1'b1, 32'h40, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 32'h24, 1'b1, 32'h44, 1'b1, 32'h40);
    cycle(1'b0, 32'h24, 1'b1, 32'h24, 1'b1, 32'h44, 1'b1, 32'h44);
    idle(32'h24);
    expect_pred("target_fix", 1'b1, 1'b1, 32'h44);

    cycle(1'b1, 32'h0, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h0);
    idle(32'h300);
    expect_pred("rst_drops_upd", 1'b0, 1'b0, 32'h304);
    idle(32'h200);
    expect_pred("rst_clears", 1'b0, 1'b0, 32'h204);

    train(32'h100, 1'b1, 32'h80);
    cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    expect_pred("same_cycle_old", 1'b1, 1'b1, 32'h80);
    idle(32'h100);
    expect_pred("same_cycle_new", 1'b1, 1'b0, 32'h104);

    for (int n = 0; n < 3000; n++) begin
      logic        r, uv, ut, pt, h, mpt;
      logic [31:0] upc, utgt, ptgt, mtgt;
      r    = ($urandom_range(0, 99) == 0);
      uv   = ($urandom_range(0, 9) < 7);
      upc  = rand_pc();
      ut   = 1'($urandom_range(0, 1));
      utgt = 32'($urandom_range(0, 1023)) << 2;
      model_predict(upc, h, mpt, mtgt);
      pt   = $urandom_range(0, 1) ? mpt : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       ptgt = mtgt;
        1:       ptgt = utgt;
        default: ptgt = 32'($urandom_range(0, 1023)) << 2;
      endcase
      cycle(r, rand_pc(), uv, upc, ut, utgt, pt, ptgt);
    end

    repeat (3) idle(32'h0);
    @(negedge clk);
    #2;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
